// File: rtl/par_pkg.sv
// Shared definitions for the UART parity unit: parity mode codes, RX checker
// state encoding and the expected-parity helper used by both TX and RX paths.
package par_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'b00,
    RX_DATA     = 2'b01,
    RX_PAR_WAIT = 2'b10
  } rx_state_e;

  // acc is the XOR of all data bits; the result is the parity bit a correct
  // frame carries for the given mode.
  function automatic logic expected_parity(input logic acc, input logic [1:0] mode);
    case (mode)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/par_rx_chk.sv
// RX parity checker: accumulates sampled data bits of one frame after a start
// pulse and compares the received parity bit against the latched mode.
module par_rx_chk import par_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       par_en_i,
  input  logic [1:0] par_mode_i,
  input  logic       rx_start_i,
  input  logic       rx_bit_valid_i,
  input  logic       rx_bit_i,
  input  logic       rx_par_valid_i,
  output logic       rx_par_err_o,
  output logic       rx_chk_done_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic [1:0]    mode_q, mode_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  // Next-state logic; a start pulse outranks every other strobe in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (rx_start_i && (par_en_i || state_q != RX_IDLE)) begin
      // A start while busy abandons the current frame without a done pulse.
      state_d = par_en_i ? RX_DATA : RX_IDLE;
      cnt_d   = '0;
      acc_d   = 1'b0;
      mode_d  = par_mode_i;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        RX_DATA: begin
          if (rx_par_valid_i) begin
            // Parity arrived before all data bits: short frame.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = RX_IDLE;
          end else if (rx_bit_valid_i) begin
            acc_d = acc_q ^ rx_bit_i;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = RX_PAR_WAIT;
            end
          end
        end
        RX_PAR_WAIT: begin
          if (rx_par_valid_i) begin
            err_d   = (rx_bit_i != expected_parity(acc_q, mode_q));
            done_d  = 1'b1;
            state_d = RX_IDLE;
          end
        end
        default: begin
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      mode_q  <= PAR_EVEN;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign rx_par_err_o  = err_q;
  assign rx_chk_done_o = done_q;

endmodule

// File: rtl/par_gen_chk.sv
// UART parity unit: TX parity generation for a captured parallel frame plus
// the RX parity checker. The two paths share only the configuration inputs.
module par_gen_chk import par_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  par_en_i,
  input  logic [1:0]            par_mode_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  input  logic                  tx_busy_i,
  output logic                  tx_par_bit_o,
  input  logic                  rx_start_i,
  input  logic                  rx_bit_valid_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_par_valid_i,
  output logic                  rx_par_err_o,
  output logic                  rx_chk_done_o
);

  logic tx_capture;
  logic tx_par_bit_d, tx_par_bit_q;

  assign tx_capture = tx_valid_i && !tx_busy_i;

  // Parity for a new frame uses the configuration present at capture; otherwise hold.
  always_comb begin
    tx_par_bit_d = tx_par_bit_q;
    if (tx_capture) begin
      tx_par_bit_d = par_en_i ? expected_parity(^tx_data_i, par_mode_i) : 1'b0;
    end
  end

  // TX parity register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_par_bit_q <= 1'b0;
    end else begin
      tx_par_bit_q <= tx_par_bit_d;
    end
  end

  assign tx_par_bit_o = tx_par_bit_q;

  par_rx_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rx_chk (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .par_en_i       (par_en_i),
    .par_mode_i     (par_mode_i),
    .rx_start_i     (rx_start_i),
    .rx_bit_valid_i (rx_bit_valid_i),
    .rx_bit_i       (rx_bit_i),
    .rx_par_valid_i (rx_par_valid_i),
    .rx_par_err_o   (rx_par_err_o),
    .rx_chk_done_o  (rx_chk_done_o)
  );

endmodule
